// File: rtl/key_loader_if.sv
// rtl/key_loader_if.sv - byte-wide valid/ready handshake from the key source into key_loader
interface key_loader_if;
   logic [7:0] byteIn;
   logic       byteValid;
   logic       byteReady;

   modport master (output byteIn, output byteValid, input byteReady);
   modport slave  (input byteIn, input byteValid, output byteReady);
endinterface

// File: rtl/key_loader.sv
// rtl/key_loader.sv - assembles the 128-bit cipher key bytewise, pulses startTransition, flags keyReady
module key_loader #(
   parameter int START_CYCLES = 5,
   parameter int KEY_LATENCY  = 20
) (
   input  logic         clock,
   input  logic         reset,
   key_loader_if.slave  keyBus,
   output logic [127:0] roundKeyInput,
   output logic         startTransition,
   output logic         keyReady,
   output logic         busy
);
   typedef enum logic [1:0] {LOAD, START, WAIT, READY} stateT;

   localparam logic [7:0] startLast = 8'(START_CYCLES - 1);
   localparam logic [7:0] waitLast  = 8'(KEY_LATENCY - 1);

   stateT      state;
   logic [3:0] byteCount;
   logic [7:0] cycleCount;
   logic       accept;

   // Readiness comes from state alone so the source can never form a combinational loop through us.
   assign keyBus.byteReady = (state == LOAD) || (state == READY);
   assign busy             = (state == START) || (state == WAIT);
   assign accept           = keyBus.byteValid && keyBus.byteReady;

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= LOAD;
         byteCount       <= 4'd0;
         cycleCount      <= 8'd0;
         roundKeyInput   <= 128'h0;
         startTransition <= 1'b0;
         keyReady        <= 1'b0;
      end else begin
         if (accept) begin
            roundKeyInput[{byteCount, 3'b000} +: 8] <= keyBus.byteIn;
            byteCount                               <= byteCount + 4'd1;
         end
         case (state)
            LOAD: begin
               if (accept && byteCount == 4'd15) begin
                  state           <= START;
                  startTransition <= 1'b1;
                  cycleCount      <= 8'd0;
               end
            end
            START: begin
               if (cycleCount == startLast) begin
                  startTransition <= 1'b0;
                  cycleCount      <= 8'd0;
                  if (KEY_LATENCY == 0) begin
                     state    <= READY;
                     keyReady <= 1'b1;
                  end else begin
                     state <= WAIT;
                  end
               end else begin
                  cycleCount <= cycleCount + 8'd1;
               end
            end
            WAIT: begin
               if (cycleCount == waitLast) begin
                  state      <= READY;
                  keyReady   <= 1'b1;
                  cycleCount <= 8'd0;
               end else begin
                  cycleCount <= cycleCount + 8'd1;
               end
            end
            READY: begin
               // byteCount has wrapped to 0, so this byte starts a fresh key at [7:0].
               if (accept) begin
                  keyReady <= 1'b0;
                  state    <= LOAD;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_key_loader.sv
// tb/tb_key_loader.sv - randomized self-checking bench for key_loader against a timeline model
module tb_key_loader;
   localparam int S = 5;
   localparam int L = 20;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         resetC = 1'b1;
   logic [127:0] rki, cRki;
   logic         st, kr, busy, cSt, cKr, cBusy;

   key_loader_if bus ();
   key_loader_if cbus ();

   key_loader dut (
      .clock(clock), .reset(reset), .keyBus(bus.slave), .roundKeyInput(rki),
      .startTransition(st), .keyReady(kr), .busy(busy)
   );

   key_loader #(.START_CYCLES(1), .KEY_LATENCY(0)) dutCorner (
      .clock(clock), .reset(resetC), .keyBus(cbus.slave), .roundKeyInput(cRki),
      .startTransition(cSt), .keyReady(cKr), .busy(cBusy)
   );

   always #10 clock = ~clock;

   int compared = 0;
   int mismatched = 0;

   // Model: the key as an array of bytes, plus the edge number of the last completed key.
   logic [7:0] keyBytes[16];
   logic [7:0] known[16] = '{8'h54, 8'h68, 8'h61, 8'h74, 8'h73, 8'h20, 8'h6d, 8'h79,
                             8'h20, 8'h4b, 8'h75, 8'h6e, 8'h67, 8'h20, 8'h46, 8'h75};
   int loadCount = 0;
   int fullEdge = -1;
   int edgeNo = 0;

   task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edgeNo);
      end
   endtask

   function automatic bit modelReady();
      return (fullEdge < 0) || ((edgeNo - fullEdge) >= S + L);
   endfunction

   function automatic logic [127:0] modelKey();
      logic [127:0] k;
      for (int i = 0; i < 16; i++) k[8*i +: 8] = keyBytes[i];
      return k;
   endfunction

   task automatic checkOutputs();
      int d;
      bit loaded;
      loaded = (fullEdge >= 0);
      d = edgeNo - fullEdge;
      checkEq("startTransition", st, loaded && d < S);
      checkEq("busy", busy, loaded && d < S + L);
      checkEq("keyReady", kr, loaded && d >= S + L);
      checkEq("byteReady", bus.byteReady, modelReady());
      checkEq("roundKeyInput", rki, modelKey());
   endtask

   task automatic step(input bit rst, input bit v, input logic [7:0] b);
      bit rdy;
      reset = rst;
      bus.byteValid = v;
      bus.byteIn = b;
      rdy = modelReady();
      @(posedge clock);
      edgeNo++;
      if (rst) begin
         for (int i = 0; i < 16; i++) keyBytes[i] = 8'h00;
         loadCount = 0;
         fullEdge = -1;
      end else if (v && rdy) begin
         keyBytes[loadCount] = b;
         loadCount++;
         fullEdge = -1;
         if (loadCount == 16) begin
            loadCount = 0;
            fullEdge = edgeNo;
         end
      end
      #1;
      checkOutputs();
   endtask

   task automatic loadKnown(input bit gapped);
      for (int i = 0; i < 16; i++) begin
         if (gapped) step(0, 0, 8'hA5);
         step(0, 1, known[i]);
      end
   endtask

   initial begin
      bus.byteValid = 1'b0;
      bus.byteIn = 8'h00;
      cbus.byteValid = 1'b0;
      cbus.byteIn = 8'h00;

      // Known key, back-to-back bytes, then run past keyReady.
      step(1, 0, 8'h00);
      step(1, 0, 8'h00);
      loadKnown(0);
      checkEq("knownKey", rki, 128'h754620676e754b20796d207374616854);
      for (int i = 0; i < S + L + 2; i++) step(0, 0, 8'h00);

      // Gapped source from a fresh reset.
      step(1, 0, 8'h00);
      loadKnown(1);
      checkEq("knownKeyGapped", rki, 128'h754620676e754b20796d207374616854);

      // Source holds FF through START/WAIT; it lands on the first READY cycle.
      for (int i = 0; i < S + L + 3; i++) step(0, 1, 8'hFF);
      for (int i = 0; i < 14; i++) step(0, 1, 8'($urandom));
      for (int i = 0; i < S + L + 1; i++) step(0, 0, 8'h00);

      // Reload with zeros from READY.
      for (int i = 0; i < 16; i++) step(0, 1, 8'h00);
      checkEq("zeroKey", rki, 128'h0);
      for (int i = 0; i < S + L + 1; i++) step(0, 0, 8'h00);

      // Reset during WAIT, then reset after byte 7, each followed by a full load.
      loadKnown(0);
      for (int i = 0; i < S + 4; i++) step(0, 0, 8'h00);
      step(1, 1, 8'h11);
      loadKnown(0);
      for (int i = 0; i < S + L + 1; i++) step(0, 0, 8'h00);
      for (int i = 0; i < 7; i++) step(0, 1, 8'($urandom));
      step(1, 0, 8'h00);
      loadKnown(0);
      for (int i = 0; i < S + L + 1; i++) step(0, 0, 8'h00);

      // Random traffic with occasional resets.
      for (int i = 0; i < 1500; i++)
         step(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) != 0), 8'($urandom));

      // Minimum-parameter instance: 1-cycle pulse, keyReady on the falling edge of the pulse.
      @(posedge clock);
      @(posedge clock);
      #1;
      checkEq("cornerResetKey", cRki, 128'h0);
      checkEq("cornerResetReady", cbus.byteReady, 1'b1);
      checkEq("cornerResetKr", cKr, 1'b0);
      resetC = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cbus.byteValid = 1'b1;
         cbus.byteIn = known[15 - i];
         @(posedge clock);
         #1;
      end
      cbus.byteValid = 1'b0;
      checkEq("cornerKey", cRki, 128'h5468617473206d79204b756e67204675);
      checkEq("cornerStE", cSt, 1'b1);
      checkEq("cornerBusyE", cBusy, 1'b1);
      checkEq("cornerKrE", cKr, 1'b0);
      @(posedge clock);
      #1;
      checkEq("cornerStE1", cSt, 1'b0);
      checkEq("cornerKrE1", cKr, 1'b1);
      checkEq("cornerBusyE1", cBusy, 1'b0);
      checkEq("cornerReadyE1", cbus.byteReady, 1'b1);
      @(posedge clock);
      #1;
      checkEq("cornerKrE2", cKr, 1'b1);
      checkEq("cornerBusyE2", cBusy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
